// File: rtl/amba_ahb_mem_slave.sv
// amba_ahb_mem_slave: parametrised AHB-Lite memory slave with programmable
// wait states, byte/halfword/word/doubleword lane writes and the two-cycle
// ERROR response for out-of-range, misaligned or over-wide transfers.
module amba_ahb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic [1:0]            hresp,
  output logic                  error
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int LOC_W  = OFF_W + IDX_W;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * NBYTES);
  localparam logic [3:0] WAIT_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [LOC_W-1:0] addr_q, addr_d;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic             capture;
  logic             out_of_range;
  logic             misaligned;
  logic             too_wide;
  logic             illegal;
  logic [2:0]       size_mask;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [NBYTES-1:0] lane_en;
  logic             unused_inputs;

  // Burst type, protection and the BUSY/SEQ distinction do not affect behaviour.
  assign unused_inputs = ^{hburst, hprot, htrans[0]};

  assign idx = addr_q[LOC_W-1:OFF_W];
  assign off = addr_q[OFF_W-1:0];

  // Bus outputs are a pure function of the current state.
  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    error  = 1'b0;
    hrdata = '0;
    case (state_q)
      S_WAIT: hready = 1'b0;
      S_DATA: hrdata = mem_q[idx];
      S_ERR1: begin
        hready = 1'b0;
        hresp  = 2'b01;
        error  = 1'b1;
      end
      S_ERR2: hresp = 2'b01;
      default: ;
    endcase
  end

  // Address-phase qualification and legality of the presented transfer.
  always_comb begin
    capture      = hready && hsel && htrans[1];
    out_of_range = {1'b0, haddr} >= MEM_BYTES;
    size_mask    = (3'd1 << hsize) - 3'd1;
    misaligned   = |(haddr[2:0] & size_mask);
    too_wide     = 32'(hsize) > OFF_W;
    illegal      = out_of_range || misaligned || too_wide;
  end

  // Next-state logic; IDLE, DATA and ERR2 all accept an overlapping address phase.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_DATA;
        else              wcnt_d  = wcnt_q - 4'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (capture) begin
          addr_d  = haddr[LOC_W-1:0];
          write_d = hwrite;
          size_d  = hsize;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_CNT_INIT;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  // Byte lanes covered by the registered size starting at the registered offset.
  always_comb begin
    lane_en = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if ((i >= 32'(off)) && (i < 32'(off) + (32'd1 << size_q))) lane_en[i] = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Write commits at the edge that ends DATA; reset on that edge cancels it.
  always_ff @(posedge hclk) begin
    if (!hreset && (state_q == S_DATA) && write_q) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (lane_en[i]) mem_q[idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/amba_ahb_mem_slave.md
# amba_ahb_mem_slave

Parametrised AHB-Lite memory slave, the next generation of `amba_ahb_slave`. It adds the following over the fixed-width slave:
- configurable data width and memory depth;
- a programmable wait-state count;
- byte, halfword and word/doubleword lane writes;
- the two-cycle AHB ERROR response for illegal transfers.

It sits behind the AHB decoder and is driven by the existing AHB master/driver environment through `dut_if`.

## Interface
- ADDR_WIDTH, 32, width of haddr.
- DATA_WIDTH, 32, hwdata/hrdata width; legal values are 32 and 64.
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words; must be a power of two.
- WAIT_STATES, 0, hready-low cycles inserted per OKAY data phase; range 0..15.

Ports (clock and reset first):
- hclk  in  1  clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address.
- htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  transfer size: 000 byte, 001 halfword, 010 word, 011 doubleword.
- hburst  in  3  burst type; accepted and ignored because the master supplies every address.
- hprot  in  4  protection; accepted and ignored.
- hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- hrdata  out  DATA_WIDTH  read data.
- hready  out  1  transfer done / slave ready.
- hresp  out  2  response: 00 OKAY, 01 ERROR.
- error  out  1  one-cycle pulse on each errored transfer.

## Operation
Address-phase capture:
- An address phase is captured when hready=1 and hsel=1 and htrans is NONSEQ or SEQ.
- The slave registers haddr, hwrite and hsize.
- IDLE, BUSY or hsel=0 give a zero-wait OKAY and are never captured.

Illegal transfer (checked at capture; any one condition is an error):
- haddr >= MEM_DEPTH*DATA_WIDTH/8 (out of range);
- address not aligned to 2^hsize bytes;
- 2^hsize*8 > DATA_WIDTH.

State machine (state / hready / hresp):
- IDLE: hready=1, OKAY.
- WAIT: hready=0, OKAY; the wait counter decrements each cycle.
- DATA: hready=1, OKAY; the data phase completes in this cycle.
- ERR1: hready=0, ERROR; error=1.
- ERR2: hready=1, ERROR.

Transitions:
- A capture from IDLE, DATA or ERR2 goes to:
  - ERR1 if the transfer is illegal;
  - otherwise WAIT with counter = WAIT_STATES-1, when WAIT_STATES>0;
  - otherwise DATA.
- WAIT goes to DATA when the counter reaches 0.
- ERR1 always goes to ERR2.
- DATA or ERR2 with no new capture goes to IDLE.

Data path:
- The memory index is registered haddr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)].
- Write: commits at the rising edge that ends DATA. Only the 2^hsize byte lanes selected by the registered haddr low bits are written (little-endian). All other bytes are unchanged.
- Read: in DATA, hrdata = the full memory word at the registered index; in every other state hrdata = 0. The master picks the lanes.
- An errored transfer never writes memory and returns hrdata=0.

Memory contents are not reset.

## Timing
Reset:
- hreset=1 at a rising edge gives state IDLE, hready=1, hresp=00, hrdata=0, error=0, wait counter 0.
- A pending write is discarded.
- Reset during WAIT, ERR1 or DATA aborts the transfer, and no memory write occurs.

Latency:
- An OKAY transfer completes WAIT_STATES+1 cycles after its address phase.
- With WAIT_STATES=0, back-to-back transfers run at one per cycle.

Pipelined overlap:
- The next address phase overlaps the current DATA or ERR2 cycle.
- Read after write to the same address, back-to-back: the read returns the new data. The write commits at the same edge the read address is captured.

Error response:
- It is always exactly 2 cycles and ignores WAIT_STATES.
- A transfer presented during ERR2 is captured normally.

Bounds:
- The last legal word (index MEM_DEPTH-1) is OKAY.
- The first byte beyond it is ERROR.
- The index never wraps.

## Test plan
1. Defaults. Reset, then write word 0xDEADBEEF to 0x10, then read 0x10 with no gap. Required: hready stays high; the read data phase gives hrdata=0xDEADBEEF; hresp=00 throughout.
2. Byte lanes. Write 0x11223344 to 0x20, then byte write 0xAA to 0x21, then halfword write 0x5566 to 0x22 (the write data carries the value in lanes [15:8] and [31:16]), then read 0x20. Required: hrdata=0x5566AA44.
3. Wait states. WAIT_STATES=3: a read shows hready=0 for exactly 3 cycles, then hready=1 with valid hrdata. Back-to-back NONSEQ, SEQ, SEQ of 4-beat INCR each take 4 cycles.
4. Errors. Each of the following gives hresp=01 with hready 0 then 1, error pulsed for 1 cycle, and memory unchanged on a following read:
   - read of 0x400 (depth 256, 32-bit);
   - word write to 0x13;
   - hsize=011 with DATA_WIDTH=32.
   A valid NONSEQ presented in ERR2 completes OKAY.
5. Width and depth. DATA_WIDTH=64, MEM_DEPTH=16: a doubleword write to 0x78 followed by a read returns the full 64 bits. Address 0x80 gives ERROR.
6. Reset mid-transfer. WAIT_STATES=2: assert hreset in the second WAIT cycle of a write of 0xCAFEF00D to 0x08. Required: the next cycle shows hready=1, hresp=00, error=0, and a later read of 0x08 returns the old value.
